riscv_seq_divider: RTL



---
 rtl/riscv_mdu_pkg.sv | 25 ++
 rtl/riscv_seq_divider.sv | 129 ++++++++++++
 2 files changed

// File: rtl/riscv_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes,
// divider FSM encoding, XLEN and the conditional two's-complement helper.
package riscv_mdu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  localparam logic [1:0] DIV_IDLE = 2'b00;
  localparam logic [1:0] DIV_BUSY = 2'b01;
  localparam logic [1:0] DIV_DONE = 2'b10;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] value,
                                               input logic            neg);
    return neg ? (~value + 1'b1) : value;
  endfunction

endpackage

// File: rtl/riscv_seq_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per
// cycle, with a single-cycle path for divide-by-zero and signed overflow.
module riscv_seq_divider
  import riscv_mdu_pkg::*;
#(
  parameter int XLEN_P = riscv_mdu_pkg::XLEN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [2:0]        MDU_op_i,
  input  logic [XLEN_P-1:0] numerator_i,
  input  logic [XLEN_P-1:0] denominator_i,
  output logic [XLEN_P-1:0] quotient_o,
  output logic [XLEN_P-1:0] remainder_o,
  output logic              done_o
);

  localparam logic [4:0]        LAST_ITER = 5'd31;
  localparam logic [XLEN_P-1:0] INT_MIN   = {1'b1, {(XLEN_P-1){1'b0}}};

  logic [1:0]        state_q;
  logic [4:0]        cnt_q;
  logic [XLEN_P-1:0] dvd_q, dvs_q, rem_q, quo_q;
  logic              neg_q_q, neg_r_q;

  // Only funct3[0] matters once the MDU has routed a divide op here.
  logic       signed_op, num_neg, den_neg, div_zero, overflow;
  logic [1:0] unused_op;
  assign unused_op = MDU_op_i[2:1];
  assign signed_op = ~MDU_op_i[0];
  assign num_neg   = signed_op & numerator_i[XLEN_P-1];
  assign den_neg   = signed_op & denominator_i[XLEN_P-1];
  assign div_zero  = (denominator_i == '0);
  assign overflow  = signed_op & (numerator_i == INT_MIN) & (&denominator_i);

  logic [XLEN_P-1:0] abs_num, abs_den;
  assign abs_num = num_neg ? (~numerator_i + 1'b1)   : numerator_i;
  assign abs_den = den_neg ? (~denominator_i + 1'b1) : denominator_i;

  logic [XLEN_P:0]   rem_shift, trial;
  logic              take;
  logic [XLEN_P-1:0] rem_step, quo_step;
  assign rem_shift = {rem_q, dvd_q[XLEN_P-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};
  assign take      = ~trial[XLEN_P];
  assign rem_step  = take ? trial[XLEN_P-1:0] : rem_shift[XLEN_P-1:0];
  assign quo_step  = {quo_q[XLEN_P-2:0], take};

  // One negator per result serves both the fast path and the final load.
  logic [XLEN_P-1:0] res_q_raw, res_r_raw, res_q, res_r;
  logic              fix_q, fix_r;

  // NOTE: every output of this block gets a default first so no latch is
  // inferred on the paths that do not assign it.
  always_comb begin
    res_q_raw = quo_step;
    res_r_raw = rem_step;
    fix_q     = neg_q_q;
    fix_r     = neg_r_q;
    if (state_q == DIV_IDLE) begin
      res_q_raw = div_zero ? '1 : INT_MIN;
      res_r_raw = div_zero ? numerator_i : '0;
      fix_q     = 1'b0;
      fix_r     = 1'b0;
    end
  end

  assign res_q = cond_neg(res_q_raw, fix_q);
  assign res_r = cond_neg(res_r_raw, fix_r);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= DIV_IDLE;
      quotient_o  <= '0;
      remainder_o <= '0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        DIV_IDLE: begin
          if (start_i) begin
            if (div_zero || overflow) begin
              quotient_o  <= res_q;
              remainder_o <= res_r;
              done_o      <= 1'b1;
              state_q     <= DIV_DONE;
            end else begin
              state_q <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          if (!start_i) begin
            state_q <= DIV_IDLE;
          end else if (cnt_q == '0) begin
            quotient_o  <= res_q;
            remainder_o <= res_r;
            done_o      <= 1'b1;
            state_q     <= DIV_DONE;
          end
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  // NOTE: the iteration registers are deliberately not reset; they are
  // always loaded in the capture cycle before anything reads them.
  always_ff @(posedge clk_i) begin
    if (state_q == DIV_IDLE && start_i) begin
      dvd_q   <= abs_num;
      dvs_q   <= abs_den;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= LAST_ITER;
      neg_q_q <= num_neg ^ den_neg;
      neg_r_q <= num_neg;
    end else if (state_q == DIV_BUSY) begin
      dvd_q <= {dvd_q[XLEN_P-2:0], 1'b0};
      rem_q <= rem_step;
      quo_q <= quo_step;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule
